// File: rtl/reg_share_arb_pkg.sv
// Shared types and widths for the register-sharing round-robin arbiter.
package reg_share_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam int NREQ_DEF = 4;
    localparam int ID_W     = $clog2(NREQ_DEF);
    localparam int HOLD_W   = 4;

    // Index width for an arbitrary requester count; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_share_arb_if.sv
// Requester-side bus of the shared register: requests and write data in, grant and contents out.
interface reg_share_arb_if
    import reg_share_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) ();
    localparam int IW = id_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       we;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         gnt_id;
    logic                  busy;
    logic [WIDTH-1:0]      q;

    modport master (output req, we, wdata, input gnt, gnt_id, busy, q);
    modport slave  (input req, we, wdata, output gnt, gnt_id, busy, q);
endinterface

// File: rtl/reg_share_arb_rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, wrapping modulo NREQ.
module rr_pick
    import reg_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            pick_valid,
    output logic [IW-1:0]   pick_id
);
    int idx;

    always_comb begin
        pick_valid = 1'b0;
        pick_id    = ptr;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick_id    = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/reg_share_arb.sv
// Round-robin owner arbitration, bounded hold time and write gating for one shared register.
module reg_share_arb
    import reg_share_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           reset,
    reg_share_arb_if.slave bus
);
    localparam int                IW       = id_w(NREQ);
    localparam logic [IW-1:0]     LAST_ID  = IW'(NREQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_END = HOLD_W'(MAX_HOLD - 1);

    state_t              state, state_n;
    logic [IW-1:0]       owner, owner_n;
    logic [IW-1:0]       ptr, ptr_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0]     gnt, gnt_n;
    logic [WIDTH-1:0]    q, q_n;

    logic [IW-1:0]       next_id;
    logic [IW-1:0]       base;
    logic                pick_valid;
    logic [IW-1:0]       pick_id;
    logic                own_req;
    logic                own_we;

    assign own_req = bus.req[owner];
    assign own_we  = bus.we[owner];
    assign next_id = (owner == LAST_ID) ? '0 : owner + 1'b1;

    // While owned, the only pick that matters is the release pick, which
    // searches from owner+1 so the outgoing owner comes last.
    assign base = (state == OWNED) ? next_id : ptr;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (bus.req),
        .ptr        (base),
        .pick_valid (pick_valid),
        .pick_id    (pick_id)
    );

    always_comb begin
        state_n = state;
        owner_n = owner;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        q_n     = q;

        if (state == OWNED && own_req && own_we)
            q_n = bus.wdata[int'(owner)*WIDTH +: WIDTH];

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = OWNED;
                    owner_n = pick_id;
                    hold_n  = '0;
                    gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
                end
            end
            OWNED: begin
                hold_n = hold_cnt + 1'b1;
                if (!own_req || hold_cnt == HOLD_END) begin
                    ptr_n  = next_id;
                    hold_n = '0;
                    if (pick_valid) begin
                        owner_n = pick_id;
                        gnt_n   = {{(NREQ-1){1'b0}}, 1'b1} << pick_id;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            q        <= '0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            q        <= q_n;
        end
    end

    assign bus.gnt    = gnt;
    assign bus.gnt_id = owner;
    assign bus.busy   = (state == OWNED);
    assign bus.q      = q;
endmodule

// File: doc/reg_share_arb.md
# reg_share_arb

Round-robin arbiter that shares one synchronous-reset storage register among up to NREQ requesters. It is the controller placed in front of a WIDTH-bit bank of synchronous-reset D flip-flops:

- It decides which requester owns the register.
- It gates that requester's write data and write enable onto the bank.
- It bounds ownership time so that no requester can starve the others.

## Interface

Parameters:

- WIDTH, 8, data width of the shared register
- NREQ, 4, number of requesters (2..8)
- MAX_HOLD, 4, maximum consecutive owned cycles per grant (1..15)

Ports:

- clk  input  1  rising-edge clock, the only clock
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk only
- req  input  NREQ  per-requester request; held high while access is wanted
- we  input  NREQ  per-requester write enable; only meaningful for the owner
- wdata  input  NREQ*WIDTH  flattened write data; requester i uses bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant, registered
- gnt_id  output  $clog2(NREQ)  index of the current owner; valid when busy=1
- busy  output  1  high while state is OWNED
- q  output  WIDTH  shared register contents

## Operation

- States:
  - IDLE: no owner.
  - OWNED: one owner; gnt[owner]=1.
- Round-robin pointer ptr:
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ.
  - The first requester found with req=1 is picked.
- IDLE with any req=1 → OWNED with the picked owner, hold_cnt=0, gnt set to that requester.
- IDLE with req all zero → stay in IDLE; gnt=0.
- In OWNED, the write condition is req[owner] & we[owner].
  - When it holds, q ← wdata[owner] at that edge.
  - we from any non-owner is ignored.
- In OWNED, hold_cnt increments every cycle.
- Release occurs when either of these is true in the same cycle:
  - req[owner]=0 (no write that cycle), or
  - hold_cnt == MAX_HOLD-1 (the write, if requested, still happens on that final cycle).
- On release:
  - ptr ← owner+1 mod NREQ.
  - A new pick is made in the same cycle from the updated search order, with no IDLE bubble.
  - Any req=1 → OWNED with the new owner and hold_cnt ← 0.
  - Otherwise → IDLE.
  - The previous owner is eligible again, but only as the last in search order. If it is the sole requester, it is regranted with a fresh hold_cnt.
- gnt is one-hot or zero at all times. gnt_id holds its last value while in IDLE.

## Timing

- Reset values (all take effect on the first edge with reset=1): state=IDLE, gnt=0, gnt_id=0, busy=0, q=0, ptr=0, hold_cnt=0.
- Reset dominates every other event. A write pending in the reset cycle is discarded, including during a reset in the middle of ownership.
- Grant latency: req rises before edge k → gnt high after edge k (1 cycle).
- Write latency: gnt and we high before edge k → q shows the new value after edge k.
- Handoff: the old owner's last gnt cycle is immediately followed by the new owner's first gnt cycle. gnt never overlaps between owners and never has a gap while requests remain.
- Maximum continuous ownership is MAX_HOLD cycles. Worst-case wait for a requester that holds req high is (NREQ-1)*MAX_HOLD cycles.
- Simultaneous requests are resolved purely by ptr; there is no fixed priority.

## Structure

- Shared package reg_share_pkg contains:
  - the state enum (IDLE, OWNED)
  - localparams for the ptr/gnt_id width ($clog2(NREQ)) and the hold_cnt width (4 bits)
- One combinational sub-module, rr_pick:
  - inputs req and ptr
  - outputs pick_valid and pick_id (round-robin search)
  - used for both the IDLE pick and the release pick
- The top level contains the FSM, hold counter, ptr, registered gnt/gnt_id, and the WIDTH-bit synchronous-reset q register. Its write mux selects wdata[owner].

## Test plan

- Reset: drive reset=1 for 2 cycles with req=4'b1111 → gnt=0, busy=0, q=0. After reset falls, owner 0 is granted one cycle later.
- Single writer: req=4'b0100, we=4'b0100, wdata[2]=8'hA5 → gnt=4'b0100 after 1 cycle, q=8'hA5 after the next edge. Dropping req gives gnt=0 and busy=0 one cycle later, with q held.
- Rotation: req=4'b1111 held, MAX_HOLD=4 → the owner sequence is 0,1,2,3,0. Each owner holds exactly 4 cycles, handoffs have no gap, and gnt stays one-hot throughout.
- Non-owner write ignored: owner 1 with we[1]=0, and requester 3 drives we[3]=1 with wdata[3]=8'hFF → q is unchanged while gnt=4'b0010.
- Sole requester regrant: req=4'b0001 for 10 cycles → gnt[0] stays continuously high, and hold_cnt wraps after every 4 cycles.
- Mid-ownership reset: owner 2 writing 8'h3C when reset=1 in the same cycle → q=0, gnt=0. After reset falls, the search restarts from ptr=0.
